// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e    : sequencer states (IDLE, ACCESS, WAIT, RESP)
//   port_t     : requester index, 0 = CPU MEM-stage port, 1 = loader/debug port
//   ADDR_W_DEF : default word address width (128 words)
//   DATA_W_DEF : default data width
//   CNT_W      : latency counter width, covers MEM_LAT up to 7
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_picker.sv
// Grant selection between the two requesters.
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority
// with port 0 always winning contention.
// Ports:
//   clock, reset       : clock and async active-high reset (last-grant pointer)
//   valid0_i, valid1_i : request valids
//   accept_i           : a request is being accepted this cycle
//   grant_o            : selected port, meaningful only when a valid is high
module dmem_arb_picker
  import dmem_arb_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  valid0_i,
  input  logic  valid1_i,
  input  logic  accept_i,
  output port_t grant_o
);

`ifdef DMEM_ARB_RR_EN
  port_t last_q, last_d;

  always_comb begin
    grant_o = PORT0;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_q;
    end else if (valid1_i) begin
      grant_o = PORT1;
    end
    last_d = accept_i ? grant_o : last_q;
  end

  // Pointer resets to port 1 so that port 0 wins the first contention.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_pick;

  assign grant_o     = valid0_i ? PORT0 : PORT1;
  assign unused_pick = clock ^ reset ^ accept_i ^ valid1_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter in front of the single-port data memory.
// One transaction at a time: accept in IDLE, one mem_en cycle, wait out
// MEM_LAT, then a one-cycle response to the granted port.
// Build option: DMEM_ARB_RR_EN (round-robin grant, see dmem_arb_picker).
//
// state  | meaning
// IDLE   | waiting for a request, ready is combinational from the valids
// ACCESS | mem_en high for exactly this cycle
// WAIT   | counting down the memory latency, capture rdata when count is 1
// RESP   | resp_valid to the granted port
//
// Ports:
//   clock, reset                 : clock, async active-high reset
//   reqN_valid/we/addr/wdata     : request from port N (0 = CPU, 1 = loader)
//   reqN_ready                   : request accepted this cycle
//   respN_valid, respN_rdata     : completion pulse and read data (0 for writes)
//   mem_en/we/addr/wdata, rdata  : memory interface, outputs registered
//   busy                         : any state other than IDLE
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  state_e            state_q, state_d;
  port_t             pick, grant_q, grant_d;
  logic              accept, last_wait;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap0_q, cap0_d, cap1_q, cap1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign accept    = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign last_wait = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));

  dmem_arb_picker u_picker (
    .clock    (clock),
    .reset    (reset),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .accept_i (accept),
    .grant_o  (pick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      cnt_q    <= '0;
      cap0_q   <= '0;
      cap1_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      cnt_q    <= cnt_d;
      cap0_q   <= cap0_d;
      cap1_q   <= cap1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_WAIT;
      ST_WAIT:   if (last_wait) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Payload latch, memory strobes and read capture. mem_en/mem_we are set
  // on the accept edge so they are high exactly for the ACCESS cycle.
  always_comb begin
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    cnt_d    = cnt_q;
    cap0_d   = cap0_q;
    cap1_d   = cap1_q;
    if (accept) begin
      grant_d  = pick;
      we_d     = (pick == PORT1) ? req1_we    : req0_we;
      addr_d   = (pick == PORT1) ? req1_addr  : req0_addr;
      wdata_d  = (pick == PORT1) ? req1_wdata : req0_wdata;
      mem_en_d = 1'b1;
      mem_we_d = (pick == PORT1) ? req1_we    : req0_we;
    end
    if (state_q == ST_ACCESS) begin
      cnt_d = LAT_CNT;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Per-port capture keeps each port's rdata stable between its responses.
    if (last_wait) begin
      if (grant_q == PORT1) begin
        cap1_d = we_q ? '0 : mem_rdata;
      end else begin
        cap0_d = we_q ? '0 : mem_rdata;
      end
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    req0_ready  = accept && (pick == PORT0);
    req1_ready  = accept && (pick == PORT1);
    resp0_valid = (state_q == ST_RESP) && (grant_q == PORT0);
    resp1_valid = (state_q == ST_RESP) && (grant_q == PORT1);
    resp0_rdata = cap0_q;
    resp1_rdata = cap1_q;
    mem_en      = mem_en_q;
    mem_we      = mem_we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MEM_LAT = 4;

  typedef struct {
    int          cyc;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        port;
  } exp_t;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    int          start;
    int          abort;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        v    [2] = '{1'b0, 1'b0};
  logic        we_a [2] = '{1'b0, 1'b0};
  logic [6:0]  ad_a [2] = '{7'd0, 7'd0};
  logic [31:0] wd_a [2] = '{32'd0, 32'd0};

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_rdata, resp1_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;
  logic [6:0]  mem_addr;

  logic [31:0] mem  [128];
  logic [31:0] pipe [MEM_LAT];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  exp_t mem_q[$];
  exp_t resp_q[$];
  req_t rq0[$];
  req_t rq1[$];
  logic glog[$];

  int   acc_cyc = -100;
  int   next_free = 0;
  int   n_acc = 0;
  int   mem_en_cnt = 0;
  logic last_g = 1'b1;
  logic [31:0] ref_mem [128];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (v[0]),
    .req0_we     (we_a[0]),
    .req0_addr   (ad_a[0]),
    .req0_wdata  (wd_a[0]),
    .req0_ready  (req0_ready),
    .req1_valid  (v[1]),
    .req1_we     (we_a[1]),
    .req1_addr   (ad_a[1]),
    .req1_wdata  (wd_a[1]),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  function automatic logic [31:0] init_word(int a);
    return (a == 5) ? 32'hDEADBEEF : ((32'(a) * 32'h9E3779B9) ^ 32'h5A5A0F0F);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory device: reads appear on mem_rdata exactly MEM_LAT cycles after
  // the mem_en cycle; every other cycle the read bus carries noise.
  initial for (int i = 0; i < 128; i++) mem[i] = init_word(i);
  assign mem_rdata = pipe[MEM_LAT-1];
  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Requester driver: presents queued requests in order, holds until ready,
  // optionally abandons a request after 'abort' cycles.
  task automatic drive_port(input int p);
    req_t r;
    int   waited;
    logic have;
    @(posedge clock); #1;
    forever begin
      have = (p == 0) ? (rq0.size() != 0 && cyc >= rq0[0].start)
                      : (rq1.size() != 0 && cyc >= rq1[0].start);
      if (have) begin
        r = (p == 0) ? rq0.pop_front() : rq1.pop_front();
        v[p] = 1'b1; we_a[p] = r.we; ad_a[p] = r.addr; wd_a[p] = r.data;
        waited = 0;
        forever begin
          @(negedge clock);
          if ((p == 0) ? req0_ready : req1_ready) break;
          waited++;
          if (r.abort != 0 && waited >= r.abort) break;
          if (waited > 500) begin
            n_vec++; n_err++;
            $display("FAIL drv%0d_timeout: no ready after %0d cycles", p, waited);
            break;
          end
          @(posedge clock); #1;
        end
        @(posedge clock); #1;
        v[p] = 1'b0;
      end else begin
        v[p] = 1'b0;
        @(posedge clock); #1;
      end
    end
  endtask

  initial drive_port(0);
  initial drive_port(1);

  // Reference model: one transaction occupies MEM_LAT+3 cycles from accept;
  // grants follow the arbitration rule; expectations are queued for the monitor.
  initial begin
    logic any, w, e0, e1;
    exp_t e;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_q.delete(); resp_q.delete();
        acc_cyc = -100; next_free = 0; last_g = 1'b1;
        continue;
      end
      any = v[0] | v[1];
`ifdef DMEM_ARB_RR_EN
      w = (v[0] && v[1]) ? !last_g : (v[1] && !v[0]);
`else
      w = !v[0];
`endif
      e0 = (cyc >= next_free) && any && !w;
      e1 = (cyc >= next_free) && any && w;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("busy", busy, (cyc > acc_cyc) && (cyc < next_free));
      if (e0 || e1) begin
        e.port = w; e.we = we_a[w]; e.addr = ad_a[w];
        e.cyc  = cyc + 1; e.data = wd_a[w];
        mem_q.push_back(e);
        e.cyc  = cyc + MEM_LAT + 2;
        e.data = e.we ? 32'd0 : ref_mem[e.addr];
        resp_q.push_back(e);
        if (e.we) ref_mem[e.addr] = wd_a[w];
        acc_cyc = cyc; next_free = cyc + MEM_LAT + 3; last_g = w; n_acc++;
      end
    end
  end

  // Monitor: pops expected memory accesses and responses as they fall due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (mem_q.size() != 0 && mem_q[0].cyc == cyc) begin
        e = mem_q.pop_front();
        chk("mem_en", mem_en, 1'b1);
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.data);
      end else begin
        chk("mem_en_idle", mem_en, 1'b0);
        chk("mem_we_idle", mem_we, 1'b0);
      end
      if (mem_en) mem_en_cnt++;
      if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
        e = resp_q.pop_front();
        chk("resp_valid", {resp1_valid, resp0_valid}, e.port ? 2'b10 : 2'b01);
        chk("resp_rdata", e.port ? resp1_rdata : resp0_rdata, e.data);
      end else begin
        chk("resp_idle", {resp1_valid, resp0_valid}, 2'b00);
      end
      if (resp0_valid || resp1_valid) glog.push_back(resp1_valid);
    end
  end

  task automatic wait_quiet();
    int t = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || v[0] || v[1] ||
            mem_q.size() != 0 || resp_q.size() != 0) && t < 3000) begin
      @(posedge clock); #1; t++;
    end
    if (t >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL quiet_timeout: traffic still pending after %0d cycles", t);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic wait_acc(input int n0);
    int t = 0;
    while (n_acc == n0 && t < 500) begin
      @(posedge clock); #1; t++;
    end
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: no accept after %0d cycles", t);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
    chk({tag, "_respv"}, {resp1_valid, resp0_valid}, 2'b00);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 7'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata0"}, resp0_rdata, 32'd0);
    chk({tag, "_rdata1"}, resp1_rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n0, a, c0;
    req_t q;
    logic exp_g;

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    #2 reset = 1'b0;

    // Single read of a preloaded word on port 0.
    rq0.push_back('{we: 1'b0, addr: 7'd5, data: 32'd0, start: 0, abort: 0});
    wait_quiet();
    chk("rd5_data", resp0_rdata, 32'hDEADBEEF);

    // Port 1 write then read back at the top address.
    rq1.push_back('{we: 1'b1, addr: 7'd127, data: 32'h12345678, start: 0, abort: 0});
    wait_quiet();
    chk("wr127_rdata", resp1_rdata, 32'd0);
    rq1.push_back('{we: 1'b0, addr: 7'd127, data: 32'd0, start: 0, abort: 0});
    wait_quiet();
    chk("rd127_data", resp1_rdata, 32'h12345678);

    // Contention: three requests on each port presented together.
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      rq0.push_back('{we: 1'b0, addr: 7'(10 + i), data: 32'd0, start: 0, abort: 0});
      rq1.push_back('{we: 1'b0, addr: 7'(20 + i), data: 32'd0, start: 0, abort: 0});
    end
    wait_quiet();
    chk("grant_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = (i % 2) != 0;
`else
      exp_g = (i >= 3);
`endif
      chk($sformatf("grant_order%0d", i), (i < glog.size()) ? glog[i] : 1'bx, exp_g);
    end

    // Reset during WAIT: outputs clear at once, in-flight read is dropped.
    n0 = n_acc;
    rq0.push_back('{we: 1'b0, addr: 7'd33, data: 32'd0, start: 0, abort: 0});
    wait_acc(n0);
    a = acc_cyc;
    while (cyc < a + 2) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rstw");
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    rq1.push_back('{we: 1'b0, addr: 7'd5, data: 32'd0, start: 0, abort: 0});
    wait_quiet();
    chk("post_reset_rd", resp1_rdata, 32'hDEADBEEF);

    // Port 0 pulses valid for one cycle during RESP of a port 1 read.
    n0 = n_acc;
    c0 = mem_en_cnt;
    rq1.push_back('{we: 1'b0, addr: 7'd40, data: 32'd0, start: 0, abort: 0});
    wait_acc(n0);
    a = acc_cyc;
    rq0.push_back('{we: 1'b0, addr: 7'd41, data: 32'd0, start: a + MEM_LAT + 2, abort: 1});
    wait_quiet();
    repeat (4) @(posedge clock);
    #1;
    chk("resp_pulse_mem_en", mem_en_cnt, c0 + 1);
    chk("resp_pulse_idle", busy, 1'b0);

    // Randomized traffic from both ports, including abandoned requests.
    for (int r = 0; r < 60; r++) begin
      int k;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        q.we    = 1'($urandom_range(0, 1));
        q.addr  = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 127));
        q.data  = $urandom;
        q.start = cyc + $urandom_range(0, 8);
        q.abort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        if ($urandom_range(0, 1) != 0) rq1.push_back(q);
        else rq0.push_back(q);
      end
      repeat ($urandom_range(2, 15)) @(posedge clock);
    end
    wait_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter that shares the single-port 128-word data memory between two requesters. Port 0 is the CPU MEM-stage port; port 1 is the loader/debug port. It accepts one request at a time through a valid/ready handshake, drives the memory for exactly one cycle, waits out the memory read latency, and returns a one-cycle response to the granted requester. It sits between the CPU control FSM, the loader and the memory instance.

## Interface
- ADDR_W, 7, word address width (128 words)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req0_valid, req1_valid  in  1  request present
- req0_we, req1_we  in  1  1 = write, 0 = read
- req0_addr, req1_addr  in  ADDR_W  word address
- req0_wdata, req1_wdata  in  DATA_W  write data
- req0_ready, req1_ready  out  1  request accepted this cycle
- resp0_valid, resp1_valid  out  1  one-cycle completion pulse
- resp0_rdata, resp1_rdata  out  DATA_W  read data; 0 for writes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Reset state is IDLE.
- IDLE: if any reqN_valid, the picker selects a winner.
  - reqN_ready is combinational: state==IDLE and valid and granted.
  - The winner's we/addr/wdata are latched and the FSM moves to ACCESS.
  - With no valid, the FSM stays in IDLE.
- ACCESS: mem_en=1 for exactly one cycle, mem_we/addr/wdata come from the latch, and wait counter = MEM_LAT. Next state is WAIT.
- WAIT: the counter decrements each cycle. On the cycle it reads 1, mem_rdata is captured (or 0 is captured for a write). Next state is RESP.
- RESP: resp_valid=1 for the granted port only, with resp_rdata driven from the capture register. Next state is IDLE.
- resp_rdata holds its last value between responses.
- Requesters hold valid and the payload stable until ready. Dropping valid before ready is legal and produces no transaction.
- Simultaneous valid: exactly one port gets ready, and the loser stays pending. The loser is served no earlier than the next IDLE.
- A new request presented during ACCESS/WAIT/RESP sees ready=0 until IDLE.
- No back-to-back mem_en: there is always at least MEM_LAT+2 idle mem cycles between accesses.
- Reset mid-operation: the FSM returns to IDLE, the in-flight transaction is dropped with no response, and the memory contents are untouched.

## Timing
- Reset values: all ready/resp_valid/mem_en/mem_we/busy = 0, mem_addr/mem_wdata/resp_rdata = 0, round-robin pointer favours port 0.
- Accept at cycle T → mem_en at T+1 → rdata captured at end of T+1+MEM_LAT → resp_valid at T+2+MEM_LAT.
- Per-transaction occupancy is MEM_LAT+3 cycles; the next accept is possible at T+MEM_LAT+3.
- The memory side is fully registered. Only reqN_ready is combinational from the inputs.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin between ports.
  - On contention, the port not granted last wins.
  - The pointer updates on every accept.
  - After reset, port 0 wins the first contention.
- Undefined: fixed priority; port 0 always wins contention, and port 1 is served only when req0_valid=0 in IDLE.

## Structure
- Package dmem_arb_pkg:
  - state enum (IDLE, ACCESS, WAIT, RESP)
  - port index type
  - default ADDR_W/DATA_W constants
- Sub-module dmem_arb_picker: combinational grant from the two valids plus the last-grant pointer register. The RR logic is compiled in or out with DMEM_ARB_RR_EN.

## Test plan
- Single read, port 0, addr 5, memory preloaded 0xDEADBEEF, MEM_LAT=1 → ready at T, mem_en at T+1, resp0_valid at T+3 with 0xDEADBEEF, resp1_valid stays 0.
- Port 1 writes 0x12345678 to addr 127, then reads addr 127 → mem_we=1 with mem_addr=127 on the first mem_en, write resp rdata=0, read resp rdata=0x12345678.
- Both ports request together with RR enabled, three times → grant order 0,1,0. RR disabled → 0,0,0 while port 0 keeps requesting, and port 1 is served only after port 0 drops valid.
- MEM_LAT=4, port 0 read → resp0_valid exactly 6 cycles after accept, and busy is high for 6 cycles.
- Reset asserted during WAIT → all outputs go to 0 immediately, no resp_valid, and the next request is accepted normally from IDLE.
- Port 0 raises valid for one cycle during RESP, then drops it → no ready, no mem_en, and the FSM stays in IDLE.
